// File: rtl/mp_responder_if.sv
// Request/response bundle between a cache memory port and the mp_responder slave.
interface mp_responder_if;
  logic       req_valid;
  logic       req_wren;
  logic [7:0] req_address;
  logic [7:0] req_data;
  logic       req_ready;
  logic       resp_valid;
  logic [7:0] resp_data;

  modport master (
    output req_valid, req_wren, req_address, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_wren, req_address, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mp_responder.sv
// Timed main-memory responder: one request at a time, 256x8 array, fixed LATENCY.
// Optional feature macro: MP_WRITE_ACK_EN (writes also pulse resp_valid with the written data).
module mp_responder #(
  parameter int unsigned LATENCY  = 3,
  parameter logic [7:0]  INIT_XOR = 8'h00
) (
  input  logic          clock,
  input  logic          reset_n,
  mp_responder_if.slave bus
);

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = 4;

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("mp_responder: LATENCY must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef logic [7:0] mem_t [DEPTH];

  function automatic mem_t f_init_mem();
    mem_t m;
    for (int i = 0; i < int'(DEPTH); i++) m[i] = 8'(i) ^ INIT_XOR;
    return m;
  endfunction

  // Power-up contents only; reset deliberately leaves the array alone.
  mem_t r_mem = f_init_mem();

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wren;
  logic [7:0]       r_addr;
  logic [7:0]       r_data;
  logic             r_ready;
  logic             r_resp_valid;
  logic [7:0]       r_resp_data;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_ready_nxt;
  logic             w_resp_valid_nxt;
  logic [7:0]       w_resp_data_nxt;
  logic             w_mem_we;
  logic             w_latch;
  logic [7:0]       w_rd_data;

  assign w_rd_data      = r_mem[r_addr];
  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_ready      <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ready      <= w_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_data  <= w_resp_data_nxt;
      if (w_latch) begin
        r_wren <= bus.req_wren;
        r_addr <= bus.req_address;
        r_data <= bus.req_data;
      end
    end
  end

  // Writes land only on the BUSY->RESP edge, so a reset during BUSY drops them.
  always_ff @(posedge clock) begin
    if (w_mem_we && reset_n) r_mem[r_addr] <= r_data;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_ready_nxt      = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_resp_data_nxt  = r_resp_data;
    w_mem_we         = 1'b0;
    w_latch          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_latch     = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = S_BUSY;
        end else begin
          w_ready_nxt = 1'b1;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
          if (r_wren) begin
            w_mem_we = 1'b1;
`ifdef MP_WRITE_ACK_EN
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = r_data;
`endif
          end else begin
            w_resp_valid_nxt = 1'b1;
            w_resp_data_nxt  = w_rd_data;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/mp_responder.md
# mp_responder

Main-memory responder for the cache's miss/write-back path: accepts one read or write request at a time over a valid/ready handshake, holds a 256×8 storage array, and answers after a fixed, parameterised latency. It sits on the far side of the cache's memory interface and replaces the single-edge memory model with a timed, handshaked slave, so the cache can be tested against realistic miss penalties.

## Interface

Parameters:
- LATENCY, 3, cycles from request acceptance to response; legal range 1..15; 0 is illegal and rejected at elaboration.
- INIT_XOR, 8'h00, initial contents: mem[a] = a ^ INIT_XOR, set at time zero; not re-applied on reset.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_wren  in  1  1 = write (write-back), 0 = read (line fill).
- req_address  in  8  target address (tag).
- req_data  in  8  write data; ignored on reads.
- req_ready  out  1  high only in IDLE; request accepted on a posedge with req_valid & req_ready.
- resp_valid  out  1  one-cycle pulse marking a response.
- resp_data  out  8  read data (or written data, see Configuration); held until the next response.

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready = 1. On accept, latch wren/address/data into request registers, load 4-bit counter with LATENCY-1, go to BUSY.
- BUSY: req_ready = 0. If counter == 0, perform access and go to RESP; else decrement.
- Access: write sets mem[addr] = data; read loads resp_data from mem[addr]. Both are performed only on the BUSY->RESP edge.
- RESP: resp_valid = 1 for exactly one cycle (reads always; writes per Configuration); req_ready = 0; next state IDLE.
- No backpressure on responses: the requester must sample resp_data while resp_valid is high.
- req_valid while req_ready = 0 is ignored and does not queue. A request held high across RESP is accepted in the following IDLE cycle.
- Requests are strictly serialised, so a read after a write to the same address returns the new data.
- Asynchronous reset (reset_n low, any state, including mid-BUSY):
  - state = IDLE, counter = 0, request registers = 0.
  - req_ready = 1, resp_valid = 0, resp_data = 8'h00.
  - A pending write is dropped and memory is unmodified.
  - The memory array is never cleared by reset.

## Timing

- Accept on edge E0.
- Access and resp_data update occur on edge E0+LATENCY.
- resp_valid is high during the cycle after E0+LATENCY.
- req_ready returns high after edge E0+LATENCY+1.
- Throughput: one request per LATENCY+2 cycles. With LATENCY=1: accept E0, response cycle after E1, ready after E2.
- resp_data changes only on an access edge: on reads always; on writes only with the macro defined.

## Configuration

- MP_WRITE_ACK_EN defined: writes also produce the RESP resp_valid pulse, and resp_data = the written data.
- MP_WRITE_ACK_EN undefined: writes pass through RESP with resp_valid = 0 and resp_data unchanged. Timing and req_ready behaviour are identical in both cases.

## Test plan

- Reset then read: INIT_XOR = 8'h00, LATENCY = 3, read addr 8'h05 -> req_ready drops after E0, resp_valid pulse in the cycle after E3 with resp_data = 8'h05, req_ready high after E4.
- Write then read: write 8'h02 <- 8'hC3, then read 8'h02 -> resp_data = 8'hC3. With MP_WRITE_ACK_EN, the write also pulses resp_valid with 8'hC3; without it, no pulse on the write.
- Back-to-back with req_valid held high: two reads 8'h01 and 8'h03 -> second accepted exactly LATENCY+2 cycles after the first; responses 8'h01 then 8'h03; no requests lost or duplicated.
- Request during BUSY: pulse req_valid for 1 cycle while BUSY -> ignored, only one resp_valid pulse produced.
- Reset mid-write: write 8'h10 <- 8'hFF, assert reset_n low at E0+1 -> outputs go to reset values immediately; a later read of 8'h10 returns 8'h10 (write dropped).
- LATENCY = 1 sweep: read addr 8'hFF with INIT_XOR = 8'hA5 -> resp_data = 8'h5A in the cycle after E1.
